conv_pool: RTL and testbench
============================

# conv_pool

Downstream stage of the convolution engine. Takes the raw signed accumulator stream the convolver emits in raster order and requantizes each sample to BIT_DEPTH bits with round-half-up and saturation. Optionally applies ReLU, then performs 2x2 stride-2 max pooling with a single half-width row buffer. Pooled pixels go out as a valid-qualified stream to the next layer's line-buffer writer.

## Interface
- BIT_DEPTH, 8, width of the requantized and pooled output (signed).
- ACC_WIDTH, 20, width of the incoming signed convolution accumulator.
- IN_COLS, 26, convolution output columns per row. Must be even, ≥2.
- IN_ROWS, 26, convolution output rows per frame. Must be even, ≥2.
- QSHIFT, 4, arithmetic right-shift applied during requantization. Must be ≥1.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; clears counters and begins a new frame.
- in_valid  input  1  in_data is valid this cycle; no backpressure, always accepted.
- in_data  input  ACC_WIDTH  signed convolution result, raster order.
- out_valid  output  1  out_data holds a pooled pixel this cycle.
- out_data  output  BIT_DEPTH  signed pooled pixel.
- out_last  output  1  high with the final out_valid of the frame.
- done  output  1  level; frame fully pooled.

## Operation
- Reset (rst low): col, row, hold register and row buffer cleared to 0; out_valid, out_data, out_last, done = 0.
- Idle until start. start clears col/row/done and arms the block. in_valid is ignored while not armed or after done.
- Requantize, in ACC_WIDTH+1 bits: t = in_data + 2^(QSHIFT-1); q = t >>> QSHIFT. Saturate q to [-2^(BIT_DEPTH-1), 2^(BIT_DEPTH-1)-1].
- ReLU stage (see Configuration): q = (q < 0) ? 0 : q.
- Pool, per accepted sample at (row, col), with signed compare:
  - Even row, even col: rowbuf[col/2] = q.
  - Even row, odd col: rowbuf[col/2] = max(rowbuf[col/2], q).
  - Odd row, even col: hold = max(rowbuf[col/2], q).
  - Odd row, odd col: emit max(hold, q).
- Counters advance only on accepted samples. col wraps IN_COLS-1→0 and increments row. After (IN_ROWS-1, IN_COLS-1) the block sets done and disarms.
- Output count per frame = (IN_COLS/2)·(IN_ROWS/2), in raster order.
- start mid-frame: partial frame discarded, counters restart at (0,0). The row buffer is not cleared because it is always written on an even row before being read. start has priority over a coincident in_valid; that sample is dropped.
- start while done=1: done clears the next cycle and a new frame begins.

## Timing
- Latency: out_valid is registered and rises the cycle after the in_valid that carried the odd-row/odd-col sample.
- out_valid is a single-cycle pulse per pooled pixel. out_data holds its value until the next out_valid.
- out_last coincides with the last out_valid. done rises in the same cycle and stays high until start or reset.
- Back-to-back in_valid every cycle is supported, with no bubbles required. Gaps in in_valid stall the counters only.
- Reset asserted mid-frame: all outputs drop to 0 asynchronously; the block re-enters idle.

## Configuration
- CONV_POOL_RELU_EN defined: ReLU is applied after saturation, so outputs lie in [0, 2^(BIT_DEPTH-1)-1].
- Not defined: no ReLU; negative saturated values pass to the max pool unchanged.

## Test plan
Parameters: IN_COLS=4, IN_ROWS=4, QSHIFT=4, BIT_DEPTH=8.
- Reset: hold rst low with start toggling -> out_valid=0, out_data=0, out_last=0, done=0.
- Ramp frame: start, then in_data=16·k for k=0..15 on consecutive cycles -> outputs 5, 7, 13, 15. out_last and done are asserted with 15.
- Rounding/saturation: feed 23, 24, 4000 and -4000 at the positions of one 2x2 window; the requantized values are 1, 2, 127 and -128, so the window output is 127. Separately, a window of all -4000 -> -128 without the macro, 0 with CONV_POOL_RELU_EN.
- Gapped input: ramp frame with in_valid low on alternate cycles -> same outputs 5, 7, 13, 15. Each out_valid is one cycle after its triggering sample.
- Restart: start, 6 samples, start again, then the full ramp -> exactly 4 outputs (5, 7, 13, 15); no output derived from the aborted samples.
- Post-done: after done, continue driving in_valid for 8 cycles -> no out_valid. Then start -> done falls the next cycle.

Source files
------------

// File: rtl/conv_pool_if.sv
// rtl/conv_pool_if.sv - control and stream bundle between conv_pool and its neighbours
// master drives start and the accumulator stream; slave returns the pooled stream and done.
interface conv_pool_if #(
  parameter int BIT_DEPTH = 8,
  parameter int ACC_WIDTH = 20
);
  logic                        start;
  logic                        in_valid;
  logic signed [ACC_WIDTH-1:0] in_data;
  logic                        out_valid;
  logic signed [BIT_DEPTH-1:0] out_data;
  logic                        out_last;
  logic                        done;

  modport master (
    output start, in_valid, in_data,
    input  out_valid, out_data, out_last, done
  );

  modport slave (
    input  start, in_valid, in_data,
    output out_valid, out_data, out_last, done
  );
endinterface

// File: rtl/conv_pool.sv
// rtl/conv_pool.sv - requantize, optional ReLU and 2x2/2 max pool of a raster accumulator stream
// Optional feature macro: CONV_POOL_RELU_EN clamps negative requantized samples to zero.
module conv_pool #(
  parameter int BIT_DEPTH = 8,
  parameter int ACC_WIDTH = 20,
  parameter int IN_COLS   = 26,
  parameter int IN_ROWS   = 26,
  parameter int QSHIFT    = 4
) (
  input logic       clk,
  input logic       rst,
  conv_pool_if.slave bus
);
  localparam int CW   = (IN_COLS > 2) ? $clog2(IN_COLS) : 1;
  localparam int RW   = (IN_ROWS > 2) ? $clog2(IN_ROWS) : 1;
  localparam int HALF = IN_COLS / 2;
  localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int TW   = ACC_WIDTH + 1;
  localparam logic [CW-1:0]        COL_LAST = CW'(IN_COLS - 1);
  localparam logic [RW-1:0]        ROW_LAST = RW'(IN_ROWS - 1);
  localparam logic signed [TW-1:0] RND      = TW'(2 ** (QSHIFT - 1));
  localparam logic signed [TW-1:0] Q_MAX    = TW'(2 ** (BIT_DEPTH - 1) - 1);
  localparam logic signed [TW-1:0] Q_MIN    = TW'(-(2 ** (BIT_DEPTH - 1)));

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_DONE} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [HW-1:0] idx;
  logic          accept;
  logic          last_sample;

  logic signed [BIT_DEPTH-1:0] rowbuf_q [HALF];
  logic signed [BIT_DEPTH-1:0] hold_q;
  logic signed [BIT_DEPTH-1:0] out_data_q;
  logic                        out_valid_q;
  logic                        out_last_q;

  logic signed [TW-1:0]        t_sum;
  logic signed [TW-1:0]        q_full;
  logic signed [BIT_DEPTH-1:0] q;

  function automatic logic signed [BIT_DEPTH-1:0] smax(
    input logic signed [BIT_DEPTH-1:0] a,
    input logic signed [BIT_DEPTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  // Extra sign bit keeps the rounding add from overflowing near the accumulator limits.
  always_comb begin
    t_sum  = {bus.in_data[ACC_WIDTH-1], bus.in_data} + RND;
    q_full = t_sum >>> QSHIFT;
    if (q_full > Q_MAX) begin
      q = Q_MAX[BIT_DEPTH-1:0];
    end else if (q_full < Q_MIN) begin
      q = Q_MIN[BIT_DEPTH-1:0];
    end else begin
      q = q_full[BIT_DEPTH-1:0];
    end
`ifdef CONV_POOL_RELU_EN
    if (q < 0) begin
      q = '0;
    end
`else
`endif
  end

  assign idx         = HW'(col_q >> 1);
  assign last_sample = (row_q == ROW_LAST) && (col_q == COL_LAST);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    accept  = 1'b0;
    if (bus.start) begin
      state_d = ST_ARMED;
      col_d   = '0;
      row_d   = '0;
    end else if (state_q == ST_ARMED && bus.in_valid) begin
      accept = 1'b1;
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (last_sample) begin
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Even rows fold pairs into the half-width buffer; odd rows finish the window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < HALF; i++) begin
        rowbuf_q[i] <= '0;
      end
      hold_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      if (accept) begin
        case ({row_q[0], col_q[0]})
          2'b00: rowbuf_q[idx] <= q;
          2'b01: rowbuf_q[idx] <= smax(rowbuf_q[idx], q);
          2'b10: hold_q <= smax(rowbuf_q[idx], q);
          2'b11: begin
            out_valid_q <= 1'b1;
            out_data_q  <= smax(hold_q, q);
            out_last_q  <= last_sample;
          end
        endcase
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.done      = (state_q == ST_DONE);
endmodule

// File: tb/tb_conv_pool.sv
// tb/tb_conv_pool.sv - directed bench for conv_pool on a 4x4 frame, QSHIFT=4, 8-bit output
// Expected pooled values are hand-computed from the requantize and pool rules.
module tb_conv_pool;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_bad = 0;

  int oq_data[$];
  int oq_last[$];
  int oq_done[$];
  int oq_cyc[$];
  int trig_cyc[16];
  int ramp[16];
  int frame_b[16];
  int exp_ramp[4];
  int exp_b[4];

  conv_pool_if #(.BIT_DEPTH(8), .ACC_WIDTH(20)) bus ();

  conv_pool #(
    .BIT_DEPTH(8),
    .ACC_WIDTH(20),
    .IN_COLS  (4),
    .IN_ROWS  (4),
    .QSHIFT   (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && bus.out_valid === 1'b1) begin
      oq_data.push_back(int'(bus.out_data));
      oq_last.push_back(int'(bus.out_last));
      oq_done.push_back(int'(bus.done));
      oq_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    oq_data.delete();
    oq_last.delete();
    oq_done.delete();
    oq_cyc.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start    = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic feed_frame(input int vals[16], input bit gapped);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 20'(vals[k]);
      trig_cyc[k]  = cyc;
      if (gapped) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 20'(16 * 90);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int exp[4]);
    int trig_idx[4];
    trig_idx = '{5, 7, 13, 15};
    repeat (3) @(negedge clk);
    check({tag, " count"}, oq_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < oq_data.size()) begin
        check($sformatf("%s data%0d", tag, i), oq_data[i], exp[i]);
        check($sformatf("%s last%0d", tag, i), oq_last[i], (i == 3) ? 1 : 0);
        check($sformatf("%s done%0d", tag, i), oq_done[i], (i == 3) ? 1 : 0);
        check($sformatf("%s lat%0d", tag, i), oq_cyc[i], trig_cyc[trig_idx[i]] + 1);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) ramp[k] = 16 * k;
    frame_b  = '{23, 24, -4000, -4000,
                 4000, -4000, -4000, -4000,
                 -9, -24, 7, 8,
                 -40, -100, -8, 2040};
    exp_ramp = '{5, 7, 13, 15};
`ifdef CONV_POOL_RELU_EN
    exp_b    = '{127, 0, 0, 127};
`else
    exp_b    = '{127, -128, -1, 127};
`endif

    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.start    = ~bus.start;
      bus.in_valid = 1'b1;
      bus.in_data  = 20'(16 * 40);
    end
    check("rst out_valid", int'(bus.out_valid), 0);
    check("rst out_data", int'(bus.out_data), 0);
    check("rst out_last", int'(bus.out_last), 0);
    check("rst done", int'(bus.done), 0);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    repeat (2) @(negedge clk);
    check("idle done", int'(bus.done), 0);

    pulse_start();
    clear_q();
    feed_frame(ramp, 1'b0);
    check_frame("ramp", exp_ramp);

    clear_q();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 20'(16 * 50);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("postdone outputs", oq_data.size(), 0);
    check("postdone done held", int'(bus.done), 1);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("restart done clears", int'(bus.done), 0);

    pulse_start();
    clear_q();
    feed_frame(frame_b, 1'b0);
    check_frame("round", exp_b);

    pulse_start();
    clear_q();
    feed_frame(ramp, 1'b1);
    check_frame("gapped", exp_ramp);

    pulse_start();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 20'(16 * 100);
    end
    @(negedge clk);
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 20'(16 * 120);
    #1 clear_q();
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    feed_frame(ramp, 1'b0);
    check_frame("abort", exp_ramp);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
